// File: rtl/uart_rx.sv
// uart_rx
//
// Purpose:
//    UART receiver. Recovers frames made of one start bit, DATA_BITS data
//    bits (LSB first) and STOP_BITS stop bits (no parity) from an
//    asynchronous serial line. Each completed frame is presented on
//    data_out together with a one-cycle valid pulse when every stop bit was
//    high, or a one-cycle framing_err pulse when any stop bit was low.
//
// Parameters:
//    DATA_BITS    - data bits per frame
//    STOP_BITS    - stop bits per frame (every one of them is checked)
//    CLKS_PER_BIT - clocks per bit period, must be at least 4
//
// Ports:
//    clk         - system clock, rising edge
//    rst_n       - asynchronous active-low reset
//    in          - serial line, idle high, asynchronous to clk
//    data_out    - last received word, held until the next frame completes
//    valid       - one-cycle pulse for a frame with all stop bits high
//    framing_err - one-cycle pulse for a frame with any stop bit low

module uart_rx #(
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   output logic                 framing_err
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int SCW  = $clog2(CLKS_PER_BIT);
   localparam int MAXB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int BCW  = $clog2(MAXB + 1);

   localparam logic [SCW-1:0] HALF_LAST = SCW'(HALF - 1);
   localparam logic [SCW-1:0] BIT_LAST  = SCW'(CLKS_PER_BIT - 1);
   localparam logic [SCW-1:0] SCTR_ONE  = SCW'(1);
   localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
   localparam logic [BCW-1:0] BCTR_ONE  = BCW'(1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   state_e               state_q, state_d;
   logic                 sync1_q, in_sync_q, in_prev_q;
   logic [SCW-1:0]       sample_ctr_q, sample_ctr_d;
   logic [BCW-1:0]       bit_ctr_q, bit_ctr_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 err_q, err_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 fall_edge;
   logic                 stop_err;

   // Two-flop synchroniser plus the edge-detect history flop. All three
   // reset to 1 (idle line level) so leaving reset can never look like
   // the falling edge of a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b1;
         in_sync_q <= 1'b1;
         in_prev_q <= 1'b1;
      end else begin
         sync1_q   <= in;
         in_sync_q <= sync1_q;
         in_prev_q <= in_sync_q;
      end
   end

   // Only a high-to-low transition arms a frame, so a line held low
   // (break) produces at most one frame.
   assign fall_edge = in_prev_q & ~in_sync_q;

   // State, counters, shift register and the registered frame results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sample_ctr_q <= '0;
         bit_ctr_q    <= '0;
         shift_q      <= '0;
         err_q        <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_ctr_q <= sample_ctr_d;
         bit_ctr_q    <= bit_ctr_d;
         shift_q      <= shift_d;
         err_q        <= err_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         ferr_q       <= ferr_d;
      end
   end

   // Next-state logic. The start bit is checked half a bit period after
   // the edge; from then on every sample lands one full bit period later,
   // i.e. near the centre of each bit. The frame ends at the middle of the
   // last stop bit, which leaves half a bit of margin to catch a start bit
   // that follows with no idle gap. Data shifts in at the MSB so an
   // LSB-first stream ends up in natural bit order.
   always_comb begin
      state_d      = state_q;
      sample_ctr_d = sample_ctr_q;
      bit_ctr_d    = bit_ctr_q;
      shift_d      = shift_q;
      err_d        = err_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      ferr_d       = 1'b0;
      stop_err     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (fall_edge) begin
               sample_ctr_d = '0;
               state_d      = START;
            end
         end

         START: begin
            if (sample_ctr_q == HALF_LAST) begin
               if (in_sync_q) begin
                  state_d = IDLE;
               end else begin
                  sample_ctr_d = '0;
                  bit_ctr_d    = '0;
                  state_d      = DATA;
               end
            end else begin
               sample_ctr_d = sample_ctr_q + SCTR_ONE;
            end
         end

         DATA: begin
            if (sample_ctr_q == BIT_LAST) begin
               sample_ctr_d = '0;
               shift_d      = (shift_q >> 1) |
                              (DATA_BITS'(in_sync_q) << (DATA_BITS - 1));
               if (bit_ctr_q == DATA_LAST) begin
                  bit_ctr_d = '0;
                  err_d     = 1'b0;
                  state_d   = STOP;
               end else begin
                  bit_ctr_d = bit_ctr_q + BCTR_ONE;
               end
            end else begin
               sample_ctr_d = sample_ctr_q + SCTR_ONE;
            end
         end

         STOP: begin
            if (sample_ctr_q == BIT_LAST) begin
               sample_ctr_d = '0;
               stop_err     = err_q | ~in_sync_q;
               if (bit_ctr_q == STOP_LAST) begin
                  bit_ctr_d = '0;
                  state_d   = IDLE;
                  data_d    = shift_q;
                  valid_d   = ~stop_err;
                  ferr_d    = stop_err;
               end else begin
                  err_d     = stop_err;
                  bit_ctr_d = bit_ctr_q + BCTR_ONE;
               end
            end else begin
               sample_ctr_d = sample_ctr_q + SCTR_ONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign data_out    = data_q;
   assign valid       = valid_q;
   assign framing_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//
// Purpose:
//    Self-checking bench for uart_rx. Two receivers share clock and reset:
//    dut1 uses one stop bit, dut2 uses two, both at 16 clocks per bit.
//    Frames are driven bit by bit on each serial line; a reference model
//    predicts, from the frame contents and the cycle the start bit was
//    driven, the cycle, word and kind of every result pulse. A monitor
//    records the pulses the receivers actually produce.
//
// Ports:
//    none (top-level bench)

module tb_uart_rx;

   localparam int CPB = 16;
   localparam int H   = CPB / 2;
   localparam int DB  = 8;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       err;
   } pulse_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       line1 = 1'b1;
   logic       line2 = 1'b1;
   logic [7:0] data1, data2;
   logic       valid1, ferr1, valid2, ferr2;

   int         cyc   = 0;
   int         total = 0;
   int         bad   = 0;
   int         both1 = 0;
   int         both2 = 0;
   logic [7:0] lastWord1 = 8'h00;
   logic [7:0] lastWord2 = 8'h00;
   pulse_t     act1[$], act2[$], exp1[$], exp2[$];
   pulse_t     mon1, mon2;

   uart_rx #(.DATA_BITS(DB), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (line1),
      .data_out   (data1),
      .valid      (valid1),
      .framing_err(ferr1)
   );

   uart_rx #(.DATA_BITS(DB), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (line2),
      .data_out   (data2),
      .valid      (valid2),
      .framing_err(ferr2)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used as the time base for predicted pulse positions.
   always @(posedge clk) cyc <= cyc + 1;

   // Record every result pulse from either receiver, away from the
   // active edge, and note any cycle where both pulses are high at once.
   always @(negedge clk) begin
      if (valid1 || ferr1) begin
         mon1.cyc  = cyc;
         mon1.data = data1;
         mon1.err  = ferr1;
         act1.push_back(mon1);
         if (valid1 && ferr1) both1++;
      end
      if (valid2 || ferr2) begin
         mon2.cyc  = cyc;
         mon2.data = data2;
         mon2.err  = ferr2;
         act2.push_back(mon2);
         if (valid2 && ferr2) both2++;
      end
   end

   task automatic setLine(input int which, input logic b);
      if (which == 1) line1 = b;
      else            line2 = b;
   endtask

   // Hold one bit value on the chosen line for one full bit period.
   task automatic driveBit(input int which, input logic b);
      @(posedge clk);
      #1;
      setLine(which, b);
      repeat (CPB - 1) @(posedge clk);
   endtask

   // Drive a complete frame; startCyc is the cycle the start bit went low.
   task automatic sendFrame(input int which, input logic [7:0] word,
                            input int nStops, input logic [1:0] stops,
                            output int startCyc);
      @(posedge clk);
      #1;
      startCyc = cyc;
      setLine(which, 1'b0);
      repeat (CPB - 1) @(posedge clk);
      for (int i = 0; i < DB; i++) driveBit(which, word[i]);
      for (int i = 0; i < nStops; i++) driveBit(which, stops[i]);
   endtask

   // Reference model: the line change is seen two clocks later, the start
   // bit is checked half a bit after that, each further bit one full bit
   // later, and the result appears the clock after the last stop sample.
   task automatic expectFrame(input int which, input logic [7:0] word,
                              input int nStops, input logic [1:0] stops,
                              input int startCyc);
      pulse_t p;
      p.cyc  = startCyc + 2 + H + (DB + nStops) * CPB + 1;
      p.data = word;
      p.err  = 1'b0;
      for (int i = 0; i < nStops; i++) if (!stops[i]) p.err = 1'b1;
      if (which == 1) begin
         exp1.push_back(p);
         lastWord1 = word;
      end else begin
         exp2.push_back(p);
         lastWord2 = word;
      end
   endtask

   task automatic idle(input int which, input int n);
      if (n > 0) begin
         @(posedge clk);
         #1;
         setLine(which, 1'b1);
         repeat (n - 1) @(posedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (data1 !== 8'h00 || valid1 !== 1'b0 || ferr1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_dut1: got data=%h valid=%b ferr=%b, want 00 0 0",
                  data1, valid1, ferr1);
      end
      total++;
      if (data2 !== 8'h00 || valid2 !== 1'b0 || ferr2 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_dut2: got data=%h valid=%b ferr=%b, want 00 0 0",
                  data2, valid2, ferr2);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_frame_a5();
      int s;
      act1.delete();
      exp1.delete();
      sendFrame(1, 8'hA5, 1, 2'b01, s);
      expectFrame(1, 8'hA5, 1, 2'b01, s);
      repeat (20) @(posedge clk);
      total++;
      if (act1.size() !== exp1.size()) begin
         bad++;
         $display("[TB] FAIL a5_count: got %0d pulses, want %0d", act1.size(), exp1.size());
      end
      for (int i = 0; i < exp1.size() && i < act1.size(); i++) begin
         total++;
         if (act1[i].cyc !== exp1[i].cyc || act1[i].data !== exp1[i].data ||
             act1[i].err !== exp1[i].err) begin
            bad++;
            $display("[TB] FAIL a5_pulse: got cyc=%0d data=%h err=%b, want cyc=%0d data=%h err=%b",
                     act1[i].cyc, act1[i].data, act1[i].err,
                     exp1[i].cyc, exp1[i].data, exp1[i].err);
         end
      end
      total++;
      if (data1 !== lastWord1) begin
         bad++;
         $display("[TB] FAIL a5_hold: got data=%h, want %h", data1, lastWord1);
      end
   endtask

   task automatic test_back_to_back();
      int s0, s1;
      act1.delete();
      exp1.delete();
      sendFrame(1, 8'h00, 1, 2'b01, s0);
      sendFrame(1, 8'hFF, 1, 2'b01, s1);
      expectFrame(1, 8'h00, 1, 2'b01, s0);
      expectFrame(1, 8'hFF, 1, 2'b01, s1);
      repeat (20) @(posedge clk);
      total++;
      if (act1.size() !== exp1.size()) begin
         bad++;
         $display("[TB] FAIL b2b_count: got %0d pulses, want %0d", act1.size(), exp1.size());
      end
      for (int i = 0; i < exp1.size() && i < act1.size(); i++) begin
         total++;
         if (act1[i].cyc !== exp1[i].cyc || act1[i].data !== exp1[i].data ||
             act1[i].err !== exp1[i].err) begin
            bad++;
            $display("[TB] FAIL b2b_pulse: got cyc=%0d data=%h err=%b, want cyc=%0d data=%h err=%b",
                     act1[i].cyc, act1[i].data, act1[i].err,
                     exp1[i].cyc, exp1[i].data, exp1[i].err);
         end
      end
      if (act1.size() == 2) begin
         total++;
         if (act1[1].cyc - act1[0].cyc !== 10 * CPB) begin
            bad++;
            $display("[TB] FAIL b2b_spacing: got %0d clocks, want %0d",
                     act1[1].cyc - act1[0].cyc, 10 * CPB);
         end
      end
   endtask

   task automatic test_glitch();
      act1.delete();
      @(posedge clk);
      #1;
      line1 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      line1 = 1'b1;
      repeat (200) @(posedge clk);
      total++;
      if (act1.size() !== 0) begin
         bad++;
         $display("[TB] FAIL glitch_pulses: got %0d pulses, want 0", act1.size());
      end
      total++;
      if (data1 !== lastWord1) begin
         bad++;
         $display("[TB] FAIL glitch_data: got data=%h, want %h", data1, lastWord1);
      end
   endtask

   task automatic test_framing_error();
      int s;
      act1.delete();
      exp1.delete();
      sendFrame(1, 8'h3C, 1, 2'b00, s);
      expectFrame(1, 8'h3C, 1, 2'b00, s);
      idle(1, 40);
      total++;
      if (act1.size() !== exp1.size()) begin
         bad++;
         $display("[TB] FAIL ferr_count: got %0d pulses, want %0d", act1.size(), exp1.size());
      end
      for (int i = 0; i < exp1.size() && i < act1.size(); i++) begin
         total++;
         if (act1[i].cyc !== exp1[i].cyc || act1[i].data !== exp1[i].data ||
             act1[i].err !== exp1[i].err) begin
            bad++;
            $display("[TB] FAIL ferr_pulse: got cyc=%0d data=%h err=%b, want cyc=%0d data=%h err=%b",
                     act1[i].cyc, act1[i].data, act1[i].err,
                     exp1[i].cyc, exp1[i].data, exp1[i].err);
         end
      end
      total++;
      if (data1 !== lastWord1) begin
         bad++;
         $display("[TB] FAIL ferr_data: got data=%h, want %h", data1, lastWord1);
      end
   endtask

   task automatic test_reset_abort();
      int         s;
      logic [7:0] w;
      w = 8'h55;
      act1.delete();
      exp1.delete();
      @(posedge clk);
      #1;
      line1 = 1'b0;
      repeat (CPB - 1) @(posedge clk);
      for (int i = 0; i < 4; i++) driveBit(1, w[i]);
      @(posedge clk);
      #1;
      line1 = w[4];
      repeat (3) @(posedge clk);
      #1;
      rst_n     = 1'b0;
      line1     = 1'b1;
      lastWord1 = 8'h00;
      lastWord2 = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (data1 !== lastWord1 || valid1 !== 1'b0 || ferr1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_reset: got data=%h valid=%b ferr=%b, want %h 0 0",
                  data1, valid1, ferr1, lastWord1);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      sendFrame(1, 8'h81, 1, 2'b01, s);
      expectFrame(1, 8'h81, 1, 2'b01, s);
      repeat (20) @(posedge clk);
      total++;
      if (act1.size() !== exp1.size()) begin
         bad++;
         $display("[TB] FAIL abort_count: got %0d pulses, want %0d", act1.size(), exp1.size());
      end
      for (int i = 0; i < exp1.size() && i < act1.size(); i++) begin
         total++;
         if (act1[i].cyc !== exp1[i].cyc || act1[i].data !== exp1[i].data ||
             act1[i].err !== exp1[i].err) begin
            bad++;
            $display("[TB] FAIL abort_pulse: got cyc=%0d data=%h err=%b, want cyc=%0d data=%h err=%b",
                     act1[i].cyc, act1[i].data, act1[i].err,
                     exp1[i].cyc, exp1[i].data, exp1[i].err);
         end
      end
   endtask

   task automatic test_two_stop();
      int s0, s1;
      act2.delete();
      exp2.delete();
      sendFrame(2, 8'h7E, 2, 2'b01, s0);
      expectFrame(2, 8'h7E, 2, 2'b01, s0);
      idle(2, 20);
      sendFrame(2, 8'h7E, 2, 2'b11, s1);
      expectFrame(2, 8'h7E, 2, 2'b11, s1);
      idle(2, 20);
      total++;
      if (act2.size() !== exp2.size()) begin
         bad++;
         $display("[TB] FAIL stop2_count: got %0d pulses, want %0d", act2.size(), exp2.size());
      end
      for (int i = 0; i < exp2.size() && i < act2.size(); i++) begin
         total++;
         if (act2[i].cyc !== exp2[i].cyc || act2[i].data !== exp2[i].data ||
             act2[i].err !== exp2[i].err) begin
            bad++;
            $display("[TB] FAIL stop2_pulse: got cyc=%0d data=%h err=%b, want cyc=%0d data=%h err=%b",
                     act2[i].cyc, act2[i].data, act2[i].err,
                     exp2[i].cyc, exp2[i].data, exp2[i].err);
         end
      end
      total++;
      if (data2 !== lastWord2 || both2 !== 0) begin
         bad++;
         $display("[TB] FAIL stop2_hold: got data=%h overlaps=%0d, want %h 0",
                  data2, both2, lastWord2);
      end
   endtask

   task automatic test_random();
      int         s;
      int         gap;
      logic [7:0] w;
      logic       stopBit;
      logic       prevBad;
      act1.delete();
      exp1.delete();
      prevBad = 1'b0;
      for (int n = 0; n < 10; n++) begin
         w       = 8'($urandom);
         stopBit = ($urandom_range(0, 3) != 0);
         gap     = $urandom_range(0, 12);
         if (prevBad && gap < 4) gap = 4;
         idle(1, gap);
         sendFrame(1, w, 1, {1'b1, stopBit}, s);
         expectFrame(1, w, 1, {1'b1, stopBit}, s);
         prevBad = ~stopBit;
      end
      idle(1, 40);
      total++;
      if (act1.size() !== exp1.size()) begin
         bad++;
         $display("[TB] FAIL rand_count: got %0d pulses, want %0d", act1.size(), exp1.size());
      end
      for (int i = 0; i < exp1.size() && i < act1.size(); i++) begin
         total++;
         if (act1[i].cyc !== exp1[i].cyc || act1[i].data !== exp1[i].data ||
             act1[i].err !== exp1[i].err) begin
            bad++;
            $display("[TB] FAIL rand_pulse %0d: got cyc=%0d data=%h err=%b, want cyc=%0d data=%h err=%b",
                     i, act1[i].cyc, act1[i].data, act1[i].err,
                     exp1[i].cyc, exp1[i].data, exp1[i].err);
         end
      end
      total++;
      if (data1 !== lastWord1 || both1 !== 0) begin
         bad++;
         $display("[TB] FAIL rand_hold: got data=%h overlaps=%0d, want %h 0",
                  data1, both1, lastWord1);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_frame_a5();
      test_back_to_back();
      test_glitch();
      test_framing_error();
      test_reset_abort();
      test_two_stop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
